// File: rtl/onehot_sweep_pkg.sv
// onehot_sweep_pkg
//   Shared definitions for the home/peak sweep monitor: FSM state encoding
//   and the position helpers (home bit, first/last peak, next peak) for
//   either sweep direction.
package onehot_sweep_pkg;

    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        EXP_HOME = 2'd1,
        EXP_PEAK = 2'd2
    } state_t;

    function automatic int home_pos(input int width, input bit home_msb);
        return home_msb ? width - 1 : 0;
    endfunction

    function automatic int first_peak_pos(input int width, input bit home_msb);
        return home_msb ? width - 2 : 1;
    endfunction

    function automatic int last_peak_pos(input int width, input bit home_msb);
        return home_msb ? 0 : width - 1;
    endfunction

    // Peaks walk away from home one bit per sweep step, wrapping from the
    // far end back to the peak adjacent to home.
    function automatic int next_peak_pos(input int p, input int width, input bit home_msb);
        if (p == last_peak_pos(width, home_msb))
            return first_peak_pos(width, home_msb);
        return home_msb ? p - 1 : p + 1;
    endfunction

endpackage

// File: rtl/onehot_encoder.sv
// onehot_encoder
//   Combinational one-hot check and binary encode.
//   word      in   WIDTH  word to encode
//   idx       out  IDX_W  position of the single set bit; 0 if not one-hot
//   is_onehot out  1      exactly one bit of word is set
module onehot_encoder #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] word,
    output logic [IDX_W-1:0] idx,
    output logic             is_onehot
);

    logic [IDX_W-1:0] or_idx;

    always_comb begin
        // Clearing the lowest set bit leaves zero only for single-bit words.
        is_onehot = (word != '0) && ((word & (word - WIDTH'(1))) == '0);
        // OR of the positions of all set bits; exact only when one-hot,
        // so it is masked below for the zero/multi-hot cases.
        or_idx = '0;
        for (int i = 0; i < WIDTH; i++)
            if (word[i]) or_idx = or_idx | IDX_W'(i);
        idx = is_onehot ? or_idx : '0;
    end

endmodule

// File: rtl/onehot_sweep_monitor.sv
// onehot_sweep_monitor
//   Checks the home/peak sweep generator word: encodes it, tracks the
//   home/peak alternation and counts completed sweeps and violations.
//   clk        in   1      rising-edge clock
//   rstn       in   1      asynchronous active-low reset
//   pat_valid  in   1      sample pat_in this cycle
//   pat_in     in   WIDTH  generator word
//   idx        out  IDX_W  index of last sampled word (0 if not one-hot)
//   onehot_ok  out  1      last sampled word was one-hot
//   locked     out  1      tracking the sweep (not hunting)
//   seq_err    out  1      pulse: sequence violation
//   sweep_done out  1      pulse: final peak confirmed
//   sweep_cnt  out  CNT_W  completed sweeps, wrapping
//   err_cnt    out  CNT_W  violations, saturating
module onehot_sweep_monitor
    import onehot_sweep_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  bit HOME_MSB = 1'b0,
    parameter  int CNT_W    = 8,
    localparam int IDX_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             pat_valid,
    input  logic [WIDTH-1:0] pat_in,
    output logic [IDX_W-1:0] idx,
    output logic             onehot_ok,
    output logic             locked,
    output logic             seq_err,
    output logic             sweep_done,
    output logic [CNT_W-1:0] sweep_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int               HOME_POS  = home_pos(WIDTH, HOME_MSB);
    localparam logic [WIDTH-1:0] HOME_WORD = WIDTH'(1) << HOME_POS;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(last_peak_pos(WIDTH, HOME_MSB));

    logic [IDX_W-1:0] enc_idx;
    logic             enc_ok;

    onehot_encoder #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_enc (
        .word      (pat_in),
        .idx       (enc_idx),
        .is_onehot (enc_ok)
    );

    state_t           state, nxt_state;
    logic [IDX_W-1:0] last_peak, nxt_last;
    logic [IDX_W-1:0] exp_peak, nxt_exp;
    logic             err_ev, done_ev;

    // State, tracking registers, sampled word info, pulses and counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= HUNT;
            last_peak  <= '0;
            exp_peak   <= '0;
            idx        <= '0;
            onehot_ok  <= 1'b0;
            seq_err    <= 1'b0;
            sweep_done <= 1'b0;
            sweep_cnt  <= '0;
            err_cnt    <= '0;
        end else begin
            state      <= nxt_state;
            last_peak  <= nxt_last;
            exp_peak   <= nxt_exp;
            seq_err    <= err_ev;
            sweep_done <= done_ev;
            if (pat_valid) begin
                idx       <= enc_idx;
                onehot_ok <= enc_ok;
            end
            if (done_ev) sweep_cnt <= sweep_cnt + CNT_W'(1);
            if (err_ev && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
        end
    end

    // Next state. Events only arise on valid samples; a violation drops
    // to HUNT without reusing the offending word for resync.
    always_comb begin
        nxt_state = state;
        nxt_last  = last_peak;
        nxt_exp   = exp_peak;
        err_ev    = 1'b0;
        done_ev   = 1'b0;
        if (pat_valid) begin
            case (state)
                HUNT: begin
                    if (enc_ok && pat_in != HOME_WORD) begin
                        nxt_state = EXP_HOME;
                        nxt_last  = enc_idx;
                    end
                end
                EXP_HOME: begin
                    if (pat_in == HOME_WORD) begin
                        nxt_state = EXP_PEAK;
                        nxt_exp   = IDX_W'(next_peak_pos(int'(last_peak), WIDTH, HOME_MSB));
                    end else begin
                        nxt_state = HUNT;
                        err_ev    = 1'b1;
                    end
                end
                EXP_PEAK: begin
                    // exp_peak is never the home bit, so a home word fails here.
                    if (enc_ok && enc_idx == exp_peak) begin
                        nxt_state = EXP_HOME;
                        nxt_last  = exp_peak;
                        done_ev   = (exp_peak == LAST_IDX);
                    end else begin
                        nxt_state = HUNT;
                        err_ev    = 1'b1;
                    end
                end
                default: nxt_state = HUNT;
            endcase
        end
    end

    // Moore output.
    always_comb begin
        locked = (state != HUNT);
    end

endmodule

// File: tb/tb_onehot_sweep_monitor.sv
// Bench for onehot_sweep_monitor. Three instances: LSB home (CNT_W 8),
// MSB home (CNT_W 8) and LSB home with CNT_W 2. The reference model tracks
// a position in the canonical sweep sequence array rather than FSM states.
module tb_onehot_sweep_monitor;

    localparam int L = 14;   // sequence period for WIDTH 8

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       v[3];
    logic [7:0] w[3];

    logic [2:0] d_idx[3];
    logic       d_ok[3], d_lock[3], d_err[3], d_done[3];
    logic [7:0] d_scnt[3], d_ecnt[3];
    logic [1:0] s2, e2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    onehot_sweep_monitor dut0 (
        .clk(clk), .rstn(rstn), .pat_valid(v[0]), .pat_in(w[0]),
        .idx(d_idx[0]), .onehot_ok(d_ok[0]), .locked(d_lock[0]), .seq_err(d_err[0]),
        .sweep_done(d_done[0]), .sweep_cnt(d_scnt[0]), .err_cnt(d_ecnt[0]));

    onehot_sweep_monitor #(.HOME_MSB(1'b1)) dut1 (
        .clk(clk), .rstn(rstn), .pat_valid(v[1]), .pat_in(w[1]),
        .idx(d_idx[1]), .onehot_ok(d_ok[1]), .locked(d_lock[1]), .seq_err(d_err[1]),
        .sweep_done(d_done[1]), .sweep_cnt(d_scnt[1]), .err_cnt(d_ecnt[1]));

    onehot_sweep_monitor #(.CNT_W(2)) dut2 (
        .clk(clk), .rstn(rstn), .pat_valid(v[2]), .pat_in(w[2]),
        .idx(d_idx[2]), .onehot_ok(d_ok[2]), .locked(d_lock[2]), .seq_err(d_err[2]),
        .sweep_done(d_done[2]), .sweep_cnt(s2), .err_cnt(e2));

    assign d_scnt[2] = {6'd0, s2};
    assign d_ecnt[2] = {6'd0, e2};

    // ---------------- reference model ----------------
    int m_pos[3];          // index into the sweep sequence, -1 = hunting
    int m_idx[3], m_scnt[3], m_ecnt[3];
    bit m_ok[3], m_err[3], m_done[3];
    int cnt_max[3] = '{255, 255, 3};
    bit msb[3]     = '{1'b0, 1'b1, 1'b0};

    // Sequence: even slots are home, odd slot 2j+1 is the j-th peak.
    function automatic logic [7:0] seq_word(input int k, input int i);
        int j;
        if (i % 2 == 0) return msb[k] ? 8'h80 : 8'h01;
        j = i / 2;
        return msb[k] ? 8'(1 << (6 - j)) : 8'(1 << (j + 1));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_pos[k] = -1; m_idx[k] = 0; m_ok[k] = 0; m_err[k] = 0;
            m_done[k] = 0; m_scnt[k] = 0; m_ecnt[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input logic vv, input logic [7:0] ww);
        int nxt;
        m_err[k] = 0;
        m_done[k] = 0;
        if (!vv) return;
        m_ok[k] = ($countones(ww) == 1);
        m_idx[k] = 0;
        if (m_ok[k])
            for (int b = 0; b < 8; b++) if (ww[b]) m_idx[k] = b;
        if (m_pos[k] < 0) begin
            if (m_ok[k])
                for (int i = 1; i < L; i += 2) if (seq_word(k, i) == ww) m_pos[k] = i;
        end else begin
            nxt = (m_pos[k] + 1) % L;
            if (ww == seq_word(k, nxt)) begin
                m_pos[k] = nxt;
                if (nxt == L - 1) begin
                    m_done[k] = 1;
                    m_scnt[k] = (m_scnt[k] + 1) % (cnt_max[k] + 1);
                end
            end else begin
                m_pos[k] = -1;
                m_err[k] = 1;
                if (m_ecnt[k] != cnt_max[k]) m_ecnt[k]++;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("i%0d_idx", k),  int'(d_idx[k]),  m_idx[k]);
            chk($sformatf("i%0d_ok", k),   int'(d_ok[k]),   int'(m_ok[k]));
            chk($sformatf("i%0d_lock", k), int'(d_lock[k]), int'(m_pos[k] >= 0));
            chk($sformatf("i%0d_err", k),  int'(d_err[k]),  int'(m_err[k]));
            chk($sformatf("i%0d_done", k), int'(d_done[k]), int'(m_done[k]));
            chk($sformatf("i%0d_scnt", k), int'(d_scnt[k]), m_scnt[k]);
            chk($sformatf("i%0d_ecnt", k), int'(d_ecnt[k]), m_ecnt[k]);
        end
    endtask

    // Inputs are changed only at the falling edge; outputs are compared there.
    task automatic tick(input logic v0, input logic [7:0] w0, input logic v1,
                        input logic [7:0] w1, input logic v2, input logic [7:0] w2);
        v[0] = v0; w[0] = w0; v[1] = v1; w[1] = w1; v[2] = v2; w[2] = w2;
        @(posedge clk);
        if (rstn)
            for (int k = 0; k < 3; k++) model_step(k, v[k], w[k]);
        @(negedge clk);
        compare_all();
    endtask

    task automatic t0(input logic [7:0] ww);  tick(1, ww, 0, 8'h00, 0, 8'h00); endtask
    task automatic t1(input logic [7:0] ww);  tick(0, 8'h00, 1, ww, 0, 8'h00); endtask
    task automatic t2(input logic [7:0] ww);  tick(0, 8'h00, 0, 8'h00, 1, ww); endtask

    initial begin
        int pulses;
        logic [7:0] rw[3];
        logic       rv[3];
        logic [7:0] t5seq[14] = '{8'h40, 8'h80, 8'h20, 8'h80, 8'h10, 8'h80, 8'h08,
                                  8'h80, 8'h04, 8'h80, 8'h02, 8'h80, 8'h01, 8'h80};

        model_reset();
        for (int k = 0; k < 3; k++) begin v[k] = 0; w[k] = 8'h00; end
        #1 compare_all();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        tick(0, 8'h00, 0, 8'h00, 0, 8'h00);

        // 1: 30 valid cycles of the LSB-home sweep starting at 02
        for (int i = 1; i <= 30; i++) begin
            t0(seq_word(0, i % L));
            chk("t1_done_lit", int'(d_done[0]), int'(i == 13 || i == 27));
            if (i == 1) chk("t1_lock_lit", int'(d_lock[0]), 1);
        end
        chk("t1_scnt_lit", int'(d_scnt[0]), 2);
        chk("t1_ecnt_lit", int'(d_ecnt[0]), 0);

        // 2: 0x03 in place of home, then relock on the next peak
        t0(8'h04);
        t0(8'h03);
        chk("t2_ok_lit", int'(d_ok[0]), 0);
        chk("t2_idx_lit", int'(d_idx[0]), 0);
        chk("t2_err_lit", int'(d_err[0]), 1);
        chk("t2_ecnt_lit", int'(d_ecnt[0]), 1);
        chk("t2_lock_lit", int'(d_lock[0]), 0);
        t0(8'h04);
        chk("t2_relock_lit", int'(d_lock[0]), 1);
        chk("t2_pulse_lit", int'(d_err[0]), 0);

        // 3: skip a peak (..04,01,10)
        t0(8'h01);
        t0(8'h10);
        chk("t3_err_lit", int'(d_err[0]), 1);
        chk("t3_ecnt_lit", int'(d_ecnt[0]), 2);
        chk("t3_lock_lit", int'(d_lock[0]), 0);

        // 4: relock, stall 5 cycles mid-sweep, resume to completion
        t0(8'h02); t0(8'h01); t0(8'h04);
        for (int i = 0; i < 5; i++) tick(0, 8'($urandom), 0, 8'h00, 0, 8'h00);
        chk("t4_idx_hold_lit", int'(d_idx[0]), 2);
        foreach (t5seq[i]) if (i < 1) ; // keeps t5seq referenced before use
        t0(8'h01); t0(8'h08); t0(8'h01); t0(8'h10); t0(8'h01);
        t0(8'h20); t0(8'h01); t0(8'h40); t0(8'h01); t0(8'h80);
        chk("t4_done_lit", int'(d_done[0]), 1);
        chk("t4_scnt_lit", int'(d_scnt[0]), 3);
        chk("t4_ecnt_lit", int'(d_ecnt[0]), 2);

        // 5: MSB home sweep on instance 1
        for (int i = 0; i < 14; i++) begin
            t1(t5seq[i]);
            if (i == 2) chk("t5_idx20_lit", int'(d_idx[1]), 5);
            if (i == 12) chk("t5_done_lit", int'(d_done[1]), 1);
        end
        chk("t5_scnt_lit", int'(d_scnt[1]), 1);

        // 6: err_cnt saturation with CNT_W 2, then reset mid-sweep
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            t2(8'h02);
            t2(8'h03);
            pulses += int'(d_err[2]);
        end
        chk("t6_pulses_lit", pulses, 5);
        chk("t6_ecnt_lit", int'(d_ecnt[2]), 3);
        for (int i = 1; i < L; i++) t2(seq_word(2, i));
        chk("t6_done_high_lit", int'(d_done[2]), 1);
        #2 rstn = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("t6_rst_done_lit", int'(d_done[2]), 0);
        chk("t6_rst_lock_lit", int'(d_lock[2]), 0);
        tick(1, 8'h02, 1, 8'h40, 1, 8'h02);
        @(negedge clk);
        rstn = 1'b1;

        // Random phase: mostly legal continuation with injected faults/stalls
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 3; k++) begin
                int r;
                r = $urandom_range(0, 99);
                rv[k] = ($urandom_range(0, 99) < 85);
                if (r < 70)
                    rw[k] = (m_pos[k] >= 0) ? seq_word(k, (m_pos[k] + 1) % L)
                                            : seq_word(k, 1 + 2 * $urandom_range(0, 6));
                else if (r < 80) rw[k] = 8'(1 << $urandom_range(0, 7));
                else if (r < 88) rw[k] = seq_word(k, 0);
                else rw[k] = 8'($urandom);
            end
            tick(rv[0], rw[0], rv[1], rw[1], rv[2], rw[2]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
